// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  // Operand width used when the instantiating design does not override it.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller states: waiting, iterating, presenting the product for one cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand,
// then a one-bit arithmetic right shift of {accumulator, Q, Q_1}.
module booth_step #(
  parameter int unsigned N = 9
) (
  input  logic [N:0]   i_acc,
  input  logic [N-1:0] i_q,
  input  logic         i_q1,
  input  logic [N-1:0] i_m,
  output logic [N:0]   o_acc,
  output logic [N-1:0] o_q,
  output logic         o_q1
);

  logic [N:0] w_m_ext;
  logic [N:0] w_sum;

  // Booth recode {Q[0], Q_1}, then shift the whole register pair right by one.
  always_comb begin
    w_m_ext = {i_m[N-1], i_m};
    w_sum   = i_acc;
    unique case ({i_q[0], i_q1})
      2'b01:   w_sum = i_acc + w_m_ext;
      2'b10:   w_sum = i_acc - w_m_ext;
      default: w_sum = i_acc;
    endcase
    o_acc = {w_sum[N], w_sum[N:1]};
    o_q   = {w_sum[0], i_q[N-1:1]};
    o_q1  = i_q[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one iteration per clock, signed or
// unsigned operands. Operands are widened by one bit so the unsigned case is
// handled by the same signed datapath.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned N        = WIDTH + 1;
  localparam int unsigned CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             r_state;
  state_e             w_state_next;
  logic [N:0]         r_acc;
  logic [N-1:0]       r_q;
  logic               r_q1;
  logic [N-1:0]       r_m;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [N:0]         w_acc_step;
  logic [N-1:0]       w_q_step;
  logic               w_q1_step;
  logic               w_accept;
  logic               w_last;
  logic               w_ext_a;
  logic               w_ext_b;

  // Start is only honoured outside RUN; requests while busy are dropped.
  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_cnt == CNT_ONE);
  assign w_ext_a  = signed_mode & a[WIDTH-1];
  assign w_ext_b  = signed_mode & b[WIDTH-1];

  booth_step #(
    .N (N)
  ) u_step (
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_q1  (r_q1),
    .i_m   (r_m),
    .o_acc (w_acc_step),
    .o_q   (w_q_step),
    .o_q1  (w_q1_step)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = w_accept ? RUN : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand load on acceptance, one Booth iteration per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_q   <= '0;
      r_q1  <= 1'b0;
      r_m   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_q   <= {w_ext_b, b};
      r_q1  <= 1'b0;
      r_m   <= {w_ext_a, a};
      r_cnt <= CNT_LOAD;
    end else if (r_state == RUN) begin
      r_acc <= w_acc_step;
      r_q   <= w_q_step;
      r_q1  <= w_q1_step;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Capture the product from the final iteration as the FSM enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_product <= '0;
    end else if ((r_state == RUN) && w_last) begin
      r_product <= {w_acc_step[WIDTH-2:0], w_q_step};
    end
  end

  assign product = r_product;

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 4 to 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request; a new operation is accepted when start=1 and busy=0 at a rising edge.
REQ-005 signed_mode  input  1  operand interpretation: 1 means two's-complement, 0 means unsigned; sampled with start.
REQ-006 a  input  WIDTH  multiplicand; sampled at acceptance.
REQ-007 b  input  WIDTH  multiplier; sampled at acceptance.
REQ-008 busy  output  1  high while an operation is in progress (state RUN).
REQ-009 done  output  1  single-cycle pulse marking a valid product.
REQ-010 product  output  2*WIDTH  result, held stable until the next done pulse.

Function
REQ-011 The block SHALL implement a radix-2 Booth recoding multiplier, one iteration per clock.
REQ-012 Operands SHALL be extended internally to N=WIDTH+1 bits:
- sign-extended when signed_mode=1;
- zero-extended when signed_mode=0.
REQ-013 The block SHALL perform exactly N iterations per operation.
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE:
- IDLE to RUN on acceptance;
- RUN to DONE when the iteration count reaches zero;
- DONE to IDLE unconditionally, or DONE to RUN if start=1 in DONE.
REQ-015 At acceptance the block SHALL:
- clear the accumulator;
- load the multiplier register with extended b and the multiplicand register with extended a;
- clear Q_1;
- load the counter with N.
REQ-016 Each RUN cycle, based on the pair {Q[0],Q_1}, SHALL:
- add M to the accumulator for 01;
- subtract M for 10;
- leave it unchanged for 00 and 11.
REQ-017 Each RUN cycle SHALL then arithmetic-shift {accumulator, Q, Q_1} right by one and decrement the counter.
REQ-018 The accumulator SHALL be N+1 bits wide so that add/subtract never overflows before the shift.
REQ-019 product SHALL equal the low 2*WIDTH bits of {accumulator, Q} after the final iteration.
REQ-020 product SHALL be registered on the edge entering DONE.
REQ-021 Latency: done SHALL be high in the cycle that begins WIDTH+1 edges after the acceptance edge, for exactly one cycle.
REQ-022 busy SHALL be high only in RUN, so start is accepted in IDLE and in DONE (back-to-back throughput is one result per WIDTH+2 cycles).
REQ-023 start while busy=1 SHALL be ignored, with no effect on the running operation and no queuing.
REQ-024 a, b and signed_mode changes during RUN SHALL have no effect.
REQ-025 Results SHALL be exact for all operand pairs, including the most-negative times most-negative case and the unsigned all-ones times all-ones case.

Reset
REQ-026 rst=1 SHALL immediately force all of the following, independent of clk:
- state to IDLE;
- busy=0 and done=0;
- product to all zeros;
- counter, accumulator, Q and Q_1 to zero.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no done pulse; product SHALL read 0.
REQ-028 The first acceptance SHALL be possible at the first rising edge after rst deasserts.

Structure
REQ-029 Package booth_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-030 A combinational sub-module booth_step SHALL implement one iteration:
- inputs: accumulator, Q, Q_1, M;
- behaviour: add/subtract followed by the arithmetic shift;
- output: the next {accumulator, Q, Q_1}.
REQ-031 booth_mult_seq SHALL contain the FSM, counter and registers, and instantiate one booth_step.

Verification (WIDTH=8)
REQ-032 signed_mode=1, a=-3, b=5 -> done 9 cycles after acceptance, product=0xFFF1.
REQ-033 signed_mode=1, a=-128, b=-128 -> product=0x4000; and a=127, b=-128 -> product=0xC080.
REQ-034 signed_mode=0, a=255, b=255 -> product=0xFE01.
REQ-035 start held high continuously with changing operands:
- start pulses during busy are ignored;
- each accepted result is correct;
- results arrive every 10 cycles.
REQ-036 rst asserted 4 cycles into an operation -> busy, done and product go to 0 immediately, no done pulse; the next operation (a=2, b=3, signed) gives 0x0006.
REQ-037 Randomised check of 10000 operand pairs in both modes against a reference model; done SHALL pulse exactly once per accepted start.
